// File: rtl/dac_spi_tx_if.sv
// +--------------------------------------------------------------------+
// | dac_spi_tx_if : word handshake and 3-wire DAC link bundle           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface dac_spi_tx_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [WIDTH-1:0] d;
    logic             ready;
    logic             cs_n;
    logic             sclk;
    logic             sdo;
    logic             done;

    modport master (output en, d, input ready, cs_n, sclk, sdo, done);
    modport slave  (input en, d, output ready, cs_n, sclk, sdo, done);
endinterface

`default_nettype wire

// File: rtl/dac_spi_tx.sv
// +--------------------------------------------------------------------+
// | dac_spi_tx : frames a parallel word MSB-first onto cs_n/sclk/sdo    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module dac_spi_tx #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    dac_spi_tx_if.slave  bus
);
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [HW-1:0] H_LOAD = HW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [BW-1:0] B_LOAD = BW'(WIDTH - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]       state;
    logic [HW-1:0]    hcnt;
    logic [BW-1:0]    bcnt;
    logic [WIDTH-1:0] shreg;
    logic             hterm;

    assign hterm = (hcnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            hcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            bus.ready <= 1'b1;
            bus.cs_n  <= 1'b1;
            bus.sclk  <= 1'b0;
            bus.sdo   <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.en && bus.ready) begin
                        shreg     <= bus.d;
                        bus.sdo   <= bus.d[WIDTH-1];
                        bus.cs_n  <= 1'b0;
                        bus.ready <= 1'b0;
                        hcnt      <= H_LOAD;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (hterm) begin
                        hcnt  <= H_LOAD;
                        bcnt  <= B_LOAD;
                        state <= S_SHIFT;
                    end else begin
                        hcnt <= hcnt - H_ONE;
                    end
                end
                S_SHIFT: begin
                    // sclk doubles as the phase flag within each bit period
                    if (!hterm) begin
                        hcnt <= hcnt - H_ONE;
                    end else if (!bus.sclk) begin
                        bus.sclk <= 1'b1;
                        hcnt     <= H_LOAD;
                    end else begin
                        bus.sclk <= 1'b0;
                        hcnt     <= H_LOAD;
                        if (bcnt == '0) begin
                            state <= S_HOLD;
                        end else begin
                            shreg   <= {shreg[WIDTH-2:0], 1'b0};
                            bus.sdo <= shreg[WIDTH-2];
                            bcnt    <= bcnt - B_ONE;
                        end
                    end
                end
                S_HOLD: begin
                    if (hterm) begin
                        bus.cs_n <= 1'b1;
                        bus.sdo  <= 1'b0;
                        bus.done <= 1'b1;
                        hcnt     <= H_LOAD;
                        state    <= S_GAP;
                    end else begin
                        hcnt <= hcnt - H_ONE;
                    end
                end
                S_GAP: begin
                    if (hterm) begin
                        bus.ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        hcnt <= hcnt - H_ONE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    bus.ready <= 1'b1;
                    bus.cs_n  <= 1'b1;
                    bus.sclk  <= 1'b0;
                    bus.sdo   <= 1'b0;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
// +--------------------------------------------------------------------+
// | tb_dac_spi_tx : table-driven and randomized checks of dac_spi_tx    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dac_spi_tx;
    localparam int W   = 16;
    localparam int CD  = 4;
    localparam int W2  = 8;
    localparam int CD2 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dac_spi_tx_if #(.WIDTH(W))  bus_a ();
    dac_spi_tx_if #(.WIDTH(W2)) bus_b ();

    dac_spi_tx #(.WIDTH(W),  .CLK_DIV(CD))  dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    dac_spi_tx #(.WIDTH(W2), .CLK_DIV(CD2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [15:0] d;
        bit          hold;
        logic [15:0] d_after;
        logic [15:0] exp_word;
        int          exp_low;
        int          exp_rises;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // {ready, cs_n, sclk, sdo, done} for cycle i after the accepting edge (i=0 is right after it)
    function automatic logic [4:0] model(input int w, input int cd, input logic [15:0] d, input int i);
        int low;
        int j;
        int b;
        low = cd * (2 * w + 2);
        if (i < cd) return {3'b000, d[w-1], 1'b0};
        if (i < cd + 2 * cd * w) begin
            j = i - cd;
            b = j / (2 * cd);
            return {2'b00, 1'((j % (2 * cd)) >= cd), d[w-1-b], 1'b0};
        end
        if (i < low) return {3'b000, d[0], 1'b0};
        if (i < low + cd) return {2'b01, 2'b00, 1'(i == low)};
        return 5'b11000;
    endfunction

    function automatic logic [4:0] outs(input int sel);
        if (sel != 0) return {bus_b.ready, bus_b.cs_n, bus_b.sclk, bus_b.sdo, bus_b.done};
        return {bus_a.ready, bus_a.cs_n, bus_a.sclk, bus_a.sdo, bus_a.done};
    endfunction

    task automatic drive(input int sel, input logic e, input logic [15:0] dv);
        if (sel != 0) begin
            bus_b.en = e;
            bus_b.d  = dv[7:0];
        end else begin
            bus_a.en = e;
            bus_a.d  = dv;
        end
    endtask

    // Called at a negedge; sends dv, then follows the frame cycle by cycle against the model.
    task automatic run_frame(input int sel, input logic [15:0] dv, input bit hold,
                             input logic [15:0] d_after, input int abort_at,
                             output logic [15:0] got, output int lows, output int rises,
                             output int dones, output int highs, output int waited);
        int w;
        int cd;
        int last;
        logic [4:0] o;
        logic [4:0] prev;
        w    = (sel != 0) ? W2 : W;
        cd   = (sel != 0) ? CD2 : CD;
        last = cd * (2 * w + 3);
        got = '0; lows = 0; rises = 0; dones = 0; highs = 0; waited = 0;
        o = outs(sel);
        while (!o[4] && waited < 300) begin
            @(negedge clk);
            o = outs(sel);
            waited++;
        end
        if (!o[4]) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        drive(sel, 1'b1, dv);
        prev = o;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            o = outs(sel);
            if (i == abort_at) begin
                #2 rst = 1'b0;
                #1 check("async_reset", {27'd0, outs(sel)}, 32'h18);
                repeat (3) begin
                    @(negedge clk);
                    check("reset_hold", {27'd0, outs(sel)}, 32'h18);
                end
                drive(sel, 1'b0, dv);
                rst = 1'b1;
                return;
            end
            check($sformatf("cycle%0d", i), {27'd0, o}, {27'd0, model(w, cd, dv, i)});
            if (o[2] && !prev[2]) begin
                rises++;
                got = {got[14:0], o[1]};
            end
            if (!o[3]) lows++;
            if (o[0]) dones++;
            if (i >= cd * (2 * w + 2) && o[3]) highs++;
            prev = o;
            if (i < last) drive(sel, hold ? 1'b1 : 1'($urandom_range(1)), hold ? d_after : 16'($urandom));
            else          drive(sel, hold ? 1'b1 : 1'b0, d_after);
        end
    endtask

    vec_t tbl [4];

    initial begin
        logic [15:0] got;
        logic [15:0] rd;
        int lows, rises, dones, highs, waited;

        tbl[0] = '{16'hA5C3, 1'b0, 16'h0000, 16'hA5C3, 136, 16};
        tbl[1] = '{16'h0001, 1'b1, 16'hFFFF, 16'h0001, 136, 16};
        tbl[2] = '{16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 136, 16};
        tbl[3] = '{16'h3C5A, 1'b0, 16'h0000, 16'h3C5A, 136, 16};

        drive(0, 1'b0, 16'h0);
        drive(1, 1'b0, 16'h0);
        #3 rst = 1'b0;
        #1 check("rst_state_a", {27'd0, outs(0)}, 32'h18);
        check("rst_state_b", {27'd0, outs(1)}, 32'h18);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle", {27'd0, outs(0)}, 32'h18);
        end

        for (int k = 0; k < 4; k++) begin
            run_frame(0, tbl[k].d, tbl[k].hold, tbl[k].d_after, -1, got, lows, rises, dones, highs, waited);
            check($sformatf("word%0d", k), {16'd0, got}, {16'd0, tbl[k].exp_word});
            check($sformatf("cs_low%0d", k), lows, tbl[k].exp_low);
            check($sformatf("rises%0d", k), rises, tbl[k].exp_rises);
            check($sformatf("dones%0d", k), dones, 1);
            check($sformatf("gap_high%0d", k), highs, CD + 1);
            if (k > 0 && tbl[k-1].hold) check("b2b_wait", waited, 0);
        end

        // abort in the high phase of bit 7, then a clean frame
        run_frame(0, 16'hA5C3, 1'b0, 16'h0, CD + 2 * CD * 7 + CD, got, lows, rises, dones, highs, waited);
        @(negedge clk);
        run_frame(0, 16'h5AC3, 1'b0, 16'h0, -1, got, lows, rises, dones, highs, waited);
        check("post_reset_word", {16'd0, got}, 32'h5AC3);
        check("post_reset_dones", dones, 1);

        for (int r = 0; r < 5; r++) begin
            rd = 16'($urandom);
            repeat ($urandom_range(3)) @(negedge clk);
            run_frame(0, rd, 1'b0, 16'h0, -1, got, lows, rises, dones, highs, waited);
            check("rand_word", {16'd0, got}, {16'd0, rd});
            check("rand_dones", dones, 1);
        end

        run_frame(1, 16'h0081, 1'b0, 16'h0, -1, got, lows, rises, dones, highs, waited);
        check("small_word", {16'd0, got}, 32'h81);
        check("small_cs_low", lows, 18);
        check("small_rises", rises, 8);
        check("small_gap_high", highs, CD2 + 1);
        rd = 16'($urandom_range(255));
        run_frame(1, rd, 1'b0, 16'h0, -1, got, lows, rises, dones, highs, waited);
        check("small_rand_word", {16'd0, got}, {16'd0, rd});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

`default_nettype wire
